// File: rtl/tdm_sched_pkg.sv
// Shared types, default widths and derived timing helpers for the TDM multiplier scheduler.
package tdm_sched_pkg;

  typedef enum logic {
    OWN_L = 1'b0,
    OWN_H = 1'b1
  } owner_e;

  localparam int unsigned W_DEF   = 32;
  localparam int unsigned BPC_DEF = 8;

  // Cycles the iterative multiplier needs to retire all multiplier bits.
  function automatic int unsigned mul_cycles(input int unsigned w, input int unsigned bpc);
    return w / bpc;
  endfunction

  // One slot = accept cycle + multiply cycles + result cycle.
  function automatic int unsigned slot_len(input int unsigned w, input int unsigned bpc);
    return mul_cycles(w, bpc) + 2;
  endfunction

endpackage

// File: rtl/tdm_mul_sched_seq_mul.sv
// Iterative unsigned shift-add multiplier retiring BPC multiplier bits per cycle.
// Owner-agnostic: start loads operands, clear wipes all state.
module seq_mul #(
  parameter int unsigned W   = 32,
  parameter int unsigned BPC = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           clear,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] a_sh;
  logic [PW-1:0] acc;
  logic [PW-1:0] partial;
  logic [W-1:0]  b_sh;

  // Product is the accumulator plus the partial of the current digit, so the
  // final digit's sum is available in the same cycle it is computed.
  assign partial = a_sh * PW'(b_sh[BPC-1:0]);
  assign product = acc + partial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
    end else if (start) begin
      a_sh <= PW'(a);
      b_sh <= b;
      acc  <= '0;
    end else if (clear) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
    end else begin
      acc  <= product;
      a_sh <= a_sh << BPC;
      b_sh <= b_sh >> BPC;
    end
  end

endmodule

// File: rtl/tdm_mul_sched.sv
// Fixed-schedule TDM arbiter sharing one iterative multiplier between L and H requesters.
// Optional TDM_SCHED_STATS_EN adds per-side completed-operation counters.
module tdm_mul_sched
  import tdm_sched_pkg::*;
#(
  parameter int unsigned W   = W_DEF,
  parameter int unsigned BPC = BPC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           l_req_valid,
  output logic           l_req_ready,
  input  logic [W-1:0]   l_req_a,
  input  logic [W-1:0]   l_req_b,
  output logic           l_rsp_valid,
  output logic [2*W-1:0] l_rsp_data,
  input  logic           h_req_valid,
  output logic           h_req_ready,
  input  logic [W-1:0]   h_req_a,
  input  logic [W-1:0]   h_req_b,
  output logic           h_rsp_valid,
  output logic [2*W-1:0] h_rsp_data,
`ifdef TDM_SCHED_STATS_EN
  output logic [15:0]    ops_l,
  output logic [15:0]    ops_h,
`endif
  output logic           slot_owner
);

  localparam int unsigned MUL_CYCLES = mul_cycles(W, BPC);
  localparam int unsigned SLOT       = slot_len(W, BPC);
  localparam int unsigned CNT_W      = $clog2(SLOT);

  logic [CNT_W-1:0] cnt;
  owner_e           owner;
  logic             slot_start;
  logic             l_go;
  logic             h_go;
  logic             start;
  logic             active;
  logic             done;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   product;

  // Free-running slot counter; the schedule never looks at request inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      owner <= OWN_L;
    end else if (cnt == CNT_W'(SLOT - 1)) begin
      cnt   <= '0;
      owner <= (owner == OWN_L) ? OWN_H : OWN_L;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign slot_start  = (cnt == '0);
  assign slot_owner  = owner;
  assign l_req_ready = slot_start && (owner == OWN_L);
  assign h_req_ready = slot_start && (owner == OWN_H);
  assign l_go        = l_req_valid && l_req_ready;
  assign h_go        = h_req_valid && h_req_ready;
  assign start       = l_go || h_go;
  assign done        = active && (cnt == CNT_W'(MUL_CYCLES));

  // Only the side that actually transfers gets its operands onto the shared datapath.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (l_go) begin
      mul_a = l_req_a;
      mul_b = l_req_b;
    end else if (h_go) begin
      mul_a = h_req_a;
      mul_b = h_req_b;
    end
  end

  seq_mul #(
    .W   (W),
    .BPC (BPC)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .clear   (slot_start),
    .a       (mul_a),
    .b       (mul_b),
    .product (product)
  );

  // Marks a slot whose operation was accepted; idle slots stay silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
    end else if (slot_start) begin
      active <= start;
    end
  end

  // Result registers: each side's product lands only in that side's own register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_rsp_valid <= 1'b0;
      l_rsp_data  <= '0;
      h_rsp_valid <= 1'b0;
      h_rsp_data  <= '0;
    end else begin
      l_rsp_valid <= 1'b0;
      h_rsp_valid <= 1'b0;
      if (done && (owner == OWN_L)) begin
        l_rsp_valid <= 1'b1;
        l_rsp_data  <= product;
      end
      if (done && (owner == OWN_H)) begin
        h_rsp_valid <= 1'b1;
        h_rsp_data  <= product;
      end
    end
  end

`ifdef TDM_SCHED_STATS_EN
  // Counters step together with the response pulse they count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_l <= '0;
      ops_h <= '0;
    end else begin
      if (done && (owner == OWN_L)) ops_l <= ops_l + 16'd1;
      if (done && (owner == OWN_H)) ops_h <= ops_h + 16'd1;
    end
  end
`endif

endmodule
